// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and the layout of the opaque
// decoded control bundle carried from ID to EX.
package core_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CTRL_W    = 8;

    // Control bundle field layout: [3:0] alu op, [5:4] mem size, [7:6] branch type
    localparam int unsigned CTRL_ALU_OP_LSB   = 0;
    localparam int unsigned CTRL_ALU_OP_W     = 4;
    localparam int unsigned CTRL_MEM_SIZE_LSB = 4;
    localparam int unsigned CTRL_MEM_SIZE_W   = 2;
    localparam int unsigned CTRL_BR_TYPE_LSB  = 6;
    localparam int unsigned CTRL_BR_TYPE_W    = 2;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } br_type_e;

    // Extract the alu-op field from a control bundle of the default width
    function automatic logic [CTRL_ALU_OP_W-1:0] ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W];
    endfunction

    // Extract the memory-size field from a control bundle of the default width
    function automatic mem_size_e ctrl_mem_size(input logic [CTRL_W-1:0] ctrl);
        return mem_size_e'(ctrl[CTRL_MEM_SIZE_LSB +: CTRL_MEM_SIZE_W]);
    endfunction

    // Extract the branch-type field from a control bundle of the default width
    function automatic br_type_e ctrl_br_type(input logic [CTRL_W-1:0] ctrl);
        return br_type_e'(ctrl[CTRL_BR_TYPE_LSB +: CTRL_BR_TYPE_W]);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in ID/EX.
// Purely combinational so the EX forwarding logic can reuse it.
module hazard_detect
    import core_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 ex_flush,
    output logic                 hz,
    output logic                 stall_fd
);

    // A load in EX whose destination is read by ID needs one bubble; a flush
    // kills the ID instruction anyway, so it overrides the stall.
    always_comb begin
        hz       = 1'b0;
        stall_fd = 1'b0;
        if (ex_valid && ex_is_load && id_valid && (ex_rd != '0)
            && ((ex_rd == id_rs1) || (ex_rd == id_rs2))) begin
            hz = 1'b1;
        end
        stall_fd = hz & ~ex_flush;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures register_file read data (with same-cycle
// write-back bypass) and decode fields, inserts a bubble on load-use hazards
// and flushes, and counts stall and flush cycles.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int unsigned CTRL_W = core_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic [31:0]       rf_data_rs1,
    input  logic [31:0]       rf_data_rs2,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              wb_we,
    input  logic              ex_flush,
    output logic              stall_fd,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs1_val,
    output logic [31:0]       ex_rs2_val,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_is_load,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic            hz;
    logic            stall_raw;
    logic            bubble;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    hazard_detect u_hazard_detect (
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_flush   (ex_flush),
        .hz         (hz),
        .stall_fd   (stall_raw)
    );

    // Stall request to IF/ID; held low while the core is in reset
    always_comb begin
        stall_fd = stall_raw & reset_n;
        bubble   = ex_flush | stall_raw;
    end

    // Operand select: x0 reads zero, otherwise the value being written back
    // this cycle wins over the (not yet updated) register_file read data
    always_comb begin
        rs1_val = rf_data_rs1;
        rs2_val = rf_data_rs2;
        if (id_rs1 == '0) begin
            rs1_val = '0;
        end else if (wb_we && (wb_rd == id_rs1)) begin
            rs1_val = wb_data;
        end
        if (id_rs2 == '0) begin
            rs2_val = '0;
        end else if (wb_we && (wb_rd == id_rs2)) begin
            rs2_val = wb_data;
        end
    end

    // Pipeline register: flush or stall loads a fully cleared bubble, otherwise capture ID
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1_val   <= rs1_val;
            ex_rs2_val   <= rs2_val;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_ctrl;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write & id_valid & (id_rd != '0);
            ex_is_load   <= id_is_load & id_valid;
        end
    end

    // Event counters, free-running and wrapping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            stall_count <= stall_count + CNT_W'(stall_fd);
            flush_count <= flush_count + CNT_W'(ex_flush);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage, built with 4-bit counters so wrap is reachable.
module tb_id_ex_stage;

    localparam int unsigned CTRL_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clock;
    logic              reset_n;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_reg_write;
    logic              id_is_load;
    logic [31:0]       rf_data_rs1;
    logic [31:0]       rf_data_rs2;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              wb_we;
    logic              ex_flush;
    logic              stall_fd;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_rs1_val;
    logic [31:0]       ex_rs2_val;
    logic [31:0]       ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic              ex_reg_write;
    logic              ex_is_load;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    id_ex_stage #(
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .rf_data_rs1  (rf_data_rs1),
        .rf_data_rs2  (rf_data_rs2),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_we        (wb_we),
        .ex_flush     (ex_flush),
        .stall_fd     (stall_fd),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1_val   (ex_rs1_val),
        .ex_rs2_val   (ex_rs2_val),
        .ex_imm       (ex_imm),
        .ex_ctrl      (ex_ctrl),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_is_load   (ex_is_load),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic rw, input logic ld);
        id_valid     = v;
        id_pc        = pc;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
    endtask

    // Capture a lw x6 into EX, then present a consumer of x6: costs one stall
    task automatic load_use_pair();
        drive_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 32'h204, 5'd1, 5'd6, 5'd7, 1'b1, 1'b0);
        step();
    endtask

    initial begin
        reset_n     = 1'b0;
        drive_id(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        id_imm      = '0;
        id_ctrl     = '0;
        rf_data_rs1 = '0;
        rf_data_rs2 = '0;
        wb_rd       = '0;
        wb_data     = '0;
        wb_we       = 1'b0;
        ex_flush    = 1'b0;

        #12;
        check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_eq("rst_stall_fd", 32'(stall_fd), 32'd0);
        reset_n = 1'b1;
        step();

        // Pass-through
        drive_id(1'b1, 32'h100, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
        id_imm      = 32'hFFFF_FFF0;
        id_ctrl     = 8'h5A;
        rf_data_rs1 = 32'hAA;
        rf_data_rs2 = 32'hBB;
        step();
        check_eq("pt_rs1_val", ex_rs1_val, 32'hAA);
        check_eq("pt_rs2_val", ex_rs2_val, 32'hBB);
        check_eq("pt_rd", 32'(ex_rd), 32'd5);
        check_eq("pt_reg_write", 32'(ex_reg_write), 32'd1);
        check_eq("pt_valid", 32'(ex_valid), 32'd1);
        check_eq("pt_pc", ex_pc, 32'h100);
        check_eq("pt_imm", ex_imm, 32'hFFFF_FFF0);
        check_eq("pt_ctrl", 32'(ex_ctrl), 32'h5A);
        check_eq("pt_rs1_idx", 32'(ex_rs1), 32'd3);
        check_eq("pt_rs2_idx", 32'(ex_rs2), 32'd4);

        // WB bypass on rs1 only
        drive_id(1'b1, 32'h104, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0);
        rf_data_rs1 = 32'h11;
        rf_data_rs2 = 32'h33;
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h22;
        step();
        check_eq("byp_rs1", ex_rs1_val, 32'h22);
        check_eq("byp_rs2_nomatch", ex_rs2_val, 32'h33);

        // Bypass to rs2, write enable low on rs1 match
        drive_id(1'b1, 32'h108, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0);
        wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h66;
        step();
        check_eq("byp_rs2", ex_rs2_val, 32'h66);
        check_eq("byp_rs1_rf", ex_rs1_val, 32'h11);
        wb_we = 1'b0; wb_rd = 5'd7;
        step();
        check_eq("byp_we0", ex_rs1_val, 32'h11);

        // x0 never bypassed
        drive_id(1'b1, 32'h10C, 5'd0, 5'd8, 5'd9, 1'b1, 1'b0);
        rf_data_rs1 = 32'h44;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
        step();
        check_eq("byp_x0", ex_rs1_val, 32'h0);
        wb_we = 1'b0;

        // Load-use
        drive_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
        rf_data_rs1 = 32'h1;
        rf_data_rs2 = 32'h77;
        step();
        check_eq("lu_ex_is_load", 32'(ex_is_load), 32'd1);
        check_eq("lu_ex_rd", 32'(ex_rd), 32'd6);
        drive_id(1'b1, 32'h204, 5'd1, 5'd6, 5'd7, 1'b1, 1'b0);
        #1;
        check_eq("lu_stall_on", 32'(stall_fd), 32'd1);
        step();
        check_eq("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check_eq("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
        check_eq("lu_bubble_pc", ex_pc, 32'd0);
        check_eq("lu_stall_cnt", 32'(stall_count), 32'd1);
        check_eq("lu_stall_off", 32'(stall_fd), 32'd0);
        step();
        check_eq("lu_add_valid", 32'(ex_valid), 32'd1);
        check_eq("lu_add_rd", 32'(ex_rd), 32'd7);
        check_eq("lu_add_pc", ex_pc, 32'h204);
        check_eq("lu_stall_cnt2", 32'(stall_count), 32'd1);

        // Flush beats stall
        drive_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 32'h304, 5'd6, 5'd2, 5'd7, 1'b1, 1'b0);
        ex_flush = 1'b1;
        #1;
        check_eq("fl_stall_fd", 32'(stall_fd), 32'd0);
        step();
        ex_flush = 1'b0;
        check_eq("fl_valid", 32'(ex_valid), 32'd0);
        check_eq("fl_is_load", 32'(ex_is_load), 32'd0);
        check_eq("fl_flush_cnt", 32'(flush_count), 32'd1);
        check_eq("fl_stall_cnt", 32'(stall_count), 32'd1);

        // rd = 0 suppresses reg_write; invalid ID gives a bubble
        drive_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        step();
        check_eq("rd0_reg_write", 32'(ex_reg_write), 32'd0);
        check_eq("rd0_valid", 32'(ex_valid), 32'd1);
        drive_id(1'b0, 32'h404, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        step();
        check_eq("inv_valid", 32'(ex_valid), 32'd0);
        check_eq("inv_reg_write", 32'(ex_reg_write), 32'd0);
        check_eq("inv_is_load", 32'(ex_is_load), 32'd0);

        // Stall counter wrap: 15 more stalls on top of 1 -> 16 -> 0
        for (int i = 0; i < 15; i++) begin
            load_use_pair();
        end
        check_eq("wrap_stall_cnt", 32'(stall_count), 32'd0);

        // Build counters to 5 each, then reset during an active stall
        for (int i = 0; i < 5; i++) begin
            load_use_pair();
        end
        ex_flush = 1'b1;
        repeat (4) step();
        ex_flush = 1'b0;
        check_eq("pre_stall_cnt", 32'(stall_count), 32'd5);
        check_eq("pre_flush_cnt", 32'(flush_count), 32'd5);
        drive_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 32'h504, 5'd6, 5'd2, 5'd7, 1'b1, 1'b0);
        #1;
        check_eq("pre_rst_valid", 32'(ex_valid), 32'd1);
        check_eq("pre_rst_stall", 32'(stall_fd), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(ex_valid), 32'd0);
        check_eq("rst_stall", 32'(stall_fd), 32'd0);
        check_eq("rst_is_load", 32'(ex_is_load), 32'd0);
        check_eq("rst_rd", 32'(ex_rd), 32'd0);
        check_eq("rst_pc", ex_pc, 32'd0);
        check_eq("rst_stall_cnt", 32'(stall_count), 32'd0);
        check_eq("rst_flush_cnt", 32'(flush_count), 32'd0);
        #10;
        reset_n = 1'b1;
        step();
        check_eq("post_rst_valid", 32'(ex_valid), 32'd1);
        check_eq("post_rst_stall_cnt", 32'(stall_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
